// File: rtl/pipe_pkg.sv
// pipe_pkg: opcodes, NOP and instruction field positions shared by the decode-side pipeline blocks.
package pipe_pkg;
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JMP = 6'h02;
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_LW = 6'h23;
    localparam logic [31:0] NOP = 32'h0;
    localparam int OPC_LSB = 26;
    localparam int OPC_W = 6;
    localparam int RS_LSB = 21;
    localparam int RT_LSB = 16;
    localparam int REG_W = 5;
    localparam int IMM_LSB = 0;
    localparam int IMM_W = 16;
    localparam int JT_LSB = 0;
    localparam int JT_W = 20;
endpackage

// File: rtl/if_id_stage_if.sv
// if_id_stage_if: fetch <-> IF/ID link (PC + fetched word forward, stall/redirect back).
interface if_id_stage_if #(
    parameter int ADDR_W = 20,
    parameter int INSTR_W = 32
);
    logic [ADDR_W-1:0] Daddress;
    logic [INSTR_W-1:0] instr_in;
    logic stall;
    logic jumpEnable;
    logic [ADDR_W-1:0] jumpAddress;
    modport master (output Daddress, instr_in, input stall, jumpEnable, jumpAddress);
    modport slave (input Daddress, instr_in, output stall, jumpEnable, jumpAddress);
endinterface

// File: rtl/load_use_detect.sv
// load_use_detect: flags a decode instruction that needs the result of a load still in ID/EX.
module load_use_detect
    import pipe_pkg::*;
(
    input  logic             r_valid,
    input  logic [OPC_W-1:0] opcode,
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rt,
    input  logic             idex_valid,
    input  logic             idex_mem_read,
    input  logic [REG_W-1:0] idex_rt,
    output logic             hz
);
    logic rt_used;
    // rt is only a source operand for BEQ and R-type instructions
    assign rt_used = (opcode == OP_BEQ) || (opcode == OP_RTYPE);
    assign hz = r_valid && idex_valid && idex_mem_read && (idex_rt != '0) &&
                ((idex_rt == rs) || (rt_used && (idex_rt == rt)));
endmodule

// File: rtl/if_id_stage.sv
// if_id_stage: IF/ID pipeline register with load-use stall, jump/branch redirect
// and saturating stall/flush counters.
module if_id_stage
    import pipe_pkg::*;
#(
    parameter int ADDR_W = 20,
    parameter int INSTR_W = 32,
    parameter int CNT_W = 16
) (
    input  logic               clock,
    input  logic               reset,
    if_id_stage_if.slave       fif,
    input  logic               idex_valid,
    input  logic               idex_mem_read,
    input  logic [4:0]         idex_rt,
    input  logic [31:0]        rs_data,
    input  logic [31:0]        rt_data,
    output logic               id_valid,
    output logic [ADDR_W-1:0]  id_pc,
    output logic [INSTR_W-1:0] id_instr,
    output logic [4:0]         id_rs,
    output logic [4:0]         id_rt,
    output logic [CNT_W-1:0]   stall_count,
    output logic [CNT_W-1:0]   flush_count
);
    logic [ADDR_W-1:0] r_pc_q, r_pc_d;
    logic [INSTR_W-1:0] r_instr_q, r_instr_d;
    logic r_valid_q, r_valid_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [OPC_W-1:0] opcode;
    logic [IMM_W-1:0] imm16;
    logic [ADDR_W-1:0] imm_ext, beq_target, jmp_target, target;
    logic hz, redir;

    assign opcode = r_instr_q[OPC_LSB +: OPC_W];
    assign imm16 = r_instr_q[IMM_LSB +: IMM_W];
    assign id_rs = r_instr_q[RS_LSB +: REG_W];
    assign id_rt = r_instr_q[RT_LSB +: REG_W];

    load_use_detect u_lud (
        .r_valid       (r_valid_q),
        .opcode        (opcode),
        .rs            (id_rs),
        .rt            (id_rt),
        .idex_valid    (idex_valid),
        .idex_mem_read (idex_mem_read),
        .idex_rt       (idex_rt),
        .hz            (hz)
    );

    assign imm_ext = ADDR_W'($signed(imm16));
    assign beq_target = r_pc_q + ADDR_W'(1) + imm_ext;
    assign jmp_target = ADDR_W'(r_instr_q[JT_LSB +: JT_W]);
    assign target = (opcode == OP_JMP) ? jmp_target : beq_target;
    // a stalled instruction must not redirect: the PC register would take the load over the hold
    assign redir = r_valid_q && !hz &&
                   ((opcode == OP_JMP) || ((opcode == OP_BEQ) && (rs_data == rt_data)));

    assign fif.stall = hz;
    assign fif.jumpEnable = redir;
    assign fif.jumpAddress = redir ? target : '0;
    assign id_valid = r_valid_q && !hz;
    assign id_pc = r_pc_q;
    assign id_instr = r_instr_q;
    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;

    always_comb begin
        r_pc_d = hz ? r_pc_q : fif.Daddress;
        r_instr_d = hz ? r_instr_q : fif.instr_in;
        r_valid_d = hz ? r_valid_q : !redir;
        stall_cnt_d = (hz && stall_cnt_q != '1) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
        flush_cnt_d = (redir && flush_cnt_q != '1) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_pc_q <= '0;
            r_instr_q <= INSTR_W'(NOP);
            r_valid_q <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            r_pc_q <= r_pc_d;
            r_instr_q <= r_instr_d;
            r_valid_q <= r_valid_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end
endmodule
